fifo_param_core: RTL and testbench

Parametrised synchronous FIFO core: the next-generation storage block behind the FIFO verification environment's driver/monitor interface. It generalises width and depth and adds programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags and a selectable first-word-fall-through (FWFT) read mode. It sits between the driver-facing write port and the monitor-facing read port, single clock domain.

---
 rtl/fifo_param_core.sv | 123 ++++++++++++
 tb/tb_fifo_param_core.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_param_core.sv
// Parametrised synchronous FIFO core with programmable thresholds,
// occupancy count, sticky error flags and optional first-word-fall-through.
module fifo_param_core #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter bit FWFT       = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_enb,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic                       rd_enb,
    input  logic                       err_clr,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       half,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_AF    = CW'(AF_THRESH);
    localparam logic [CW-1:0] C_AE    = CW'(AE_THRESH);
    localparam logic [CW-1:0] C_HALF  = CW'(DEPTH / 2);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_afull;
    logic                  r_aempty;
    logic                  r_half;
    logic                  r_ovf;
    logic                  r_unf;

    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_ovf_set;
    logic                  w_unf_set;
    logic [CW-1:0]         w_cnt_nxt;

    // Acceptance uses the flags registered before the edge; reset blocks both.
    assign w_wr_acc  = rst && wr_enb && !r_full;
    assign w_rd_acc  = rst && rd_enb && !r_empty;
    assign w_ovf_set = wr_enb && r_full;
    assign w_unf_set = rd_enb && r_empty;
    assign w_cnt_nxt = r_count + CW'(w_wr_acc) - CW'(w_rd_acc);

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
            r_half   <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count  <= w_cnt_nxt;
            r_full   <= (w_cnt_nxt == C_DEPTH);
            r_empty  <= (w_cnt_nxt == '0);
            r_afull  <= (w_cnt_nxt >= C_AF);
            r_aempty <= (w_cnt_nxt <= C_AE);
            r_half   <= (w_cnt_nxt >= C_HALF);
            // A new error in the same cycle as err_clr keeps the flag set.
            r_ovf    <= w_ovf_set || (r_ovf && !err_clr);
            r_unf    <= w_unf_set || (r_unf && !err_clr);
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign rd_data = r_mem[r_rd_ptr];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_rd_data;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_rd_data <= '0;
                end else if (w_rd_acc) begin
                    r_rd_data <= r_mem[r_rd_ptr];
                end
            end

            assign rd_data = r_rd_data;
        end
    endgenerate

    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_afull;
    assign almost_empty = r_aempty;
    assign half         = r_half;
    assign count        = r_count;
    assign overflow     = r_ovf;
    assign underflow    = r_unf;

endmodule

// File: tb/tb_fifo_param_core.sv
// Directed bench for fifo_param_core: standard and FWFT instances share
// stimulus and are compared every cycle against a queue-based model.
module tb_fifo_param_core;

    localparam int DW = 8;
    localparam int D  = 16;
    localparam int AF = D - 2;
    localparam int AE = 2;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_enb = 1'b0;
    logic          rd_enb = 1'b0;
    logic          err_clr = 1'b0;
    logic [DW-1:0] wr_data = '0;

    logic [DW-1:0] a_rd, b_rd;
    logic          a_full, a_empty, a_af, a_ae, a_half, a_ovf, a_unf;
    logic          b_full, b_empty, b_af, b_ae, b_half, b_ovf, b_unf;
    logic [CW-1:0] a_count, b_count;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_rd = '0;
    bit            m_ovf = 1'b0;
    bit            m_unf = 1'b0;
    logic [DW-1:0] saved;

    fifo_param_core #(
        .DATA_WIDTH(DW), .DEPTH(D), .AF_THRESH(AF),
        .AE_THRESH(AE), .FWFT(1'b0)
    ) u_std (
        .clk(clk), .rst(rst), .wr_enb(wr_enb), .wr_data(wr_data),
        .rd_enb(rd_enb), .err_clr(err_clr), .rd_data(a_rd),
        .full(a_full), .empty(a_empty), .almost_full(a_af),
        .almost_empty(a_ae), .half(a_half), .count(a_count),
        .overflow(a_ovf), .underflow(a_unf)
    );

    fifo_param_core #(
        .DATA_WIDTH(DW), .DEPTH(D), .AF_THRESH(AF),
        .AE_THRESH(AE), .FWFT(1'b1)
    ) u_fwft (
        .clk(clk), .rst(rst), .wr_enb(wr_enb), .wr_data(wr_data),
        .rd_enb(rd_enb), .err_clr(err_clr), .rd_data(b_rd),
        .full(b_full), .empty(b_empty), .almost_full(b_af),
        .almost_empty(b_ae), .half(b_half), .count(b_count),
        .overflow(b_ovf), .underflow(b_unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock with the given request pattern; the model advances at the edge.
    task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r,
                       input bit c, input bit rs);
        bit was_full, was_empty;
        wr_enb  = w;
        wr_data = d;
        rd_enb  = r;
        err_clr = c;
        rst     = rs;
        @(posedge clk);
        if (!rs) begin
            mq.delete();
            m_rd  = '0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            was_full  = (mq.size() == D);
            was_empty = (mq.size() == 0);
            if (r && !was_empty) m_rd = mq.pop_front();
            if (w && !was_full) mq.push_back(d);
            m_ovf = (w && was_full) || (m_ovf && !c);
            m_unf = (r && was_empty) || (m_unf && !c);
        end
        @(negedge clk);
        wr_enb  = 1'b0;
        rd_enb  = 1'b0;
        err_clr = 1'b0;
        rst     = 1'b1;
    endtask

    task automatic wr(input logic [DW-1:0] d);
        cyc(1'b1, d, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic rd();
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic clr();
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
    endtask

    always @(negedge clk) begin
        int n;
        if (chk_en) begin
            n = mq.size();
            chk("count",   32'(a_count), 32'(n));
            chk("full",    32'(a_full),  32'(n == D));
            chk("empty",   32'(a_empty), 32'(n == 0));
            chk("afull",   32'(a_af),    32'(n >= AF));
            chk("aempty",  32'(a_ae),    32'(n <= AE));
            chk("half",    32'(a_half),  32'(n >= D / 2));
            chk("ovf",     32'(a_ovf),   32'(m_ovf));
            chk("unf",     32'(a_unf),   32'(m_unf));
            chk("rd_data", 32'(a_rd),    32'(m_rd));
            chk("f_count", 32'(b_count), 32'(n));
            chk("f_empty", 32'(b_empty), 32'(n == 0));
            chk("f_full",  32'(b_full),  32'(n == D));
            chk("f_ovf",   32'(b_ovf),   32'(m_ovf));
            chk("f_unf",   32'(b_unf),   32'(m_unf));
            if (n > 0) chk("f_head", 32'(b_rd), 32'(mq[0]));
        end
    end

    initial begin
        @(negedge clk);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
        chk("rst_count", 32'(a_count), 0);
        chk("rst_empty", 32'(a_empty), 1);
        chk("rst_ae",    32'(a_ae), 1);
        chk("rst_rd",    32'(a_rd), 0);

        // fill 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            wr(DW'(i));
            if (i == 6)  chk("half_7",  32'(a_half), 0);
            if (i == 7)  chk("half_8",  32'(a_half), 1);
            if (i == 12) chk("af_13",   32'(a_af), 0);
            if (i == 13) chk("af_14",   32'(a_af), 1);
        end
        chk("fill_full",  32'(a_full), 1);
        chk("fill_count", 32'(a_count), 16);
        wr(8'hEE);
        chk("ovf_set",   32'(a_ovf), 1);
        chk("ovf_count", 32'(a_count), 16);
        clr();
        chk("ovf_clr", 32'(a_ovf), 0);

        // drain
        for (int i = 0; i < 16; i++) begin
            rd();
            chk("drain", 32'(a_rd), 32'(i));
            if (i == 13) chk("ae_2", 32'(a_ae), 1);
            if (i == 12) chk("ae_3", 32'(a_ae), 0);
        end
        chk("drain_empty", 32'(a_empty), 1);
        rd();
        chk("unf_set",  32'(a_unf), 1);
        chk("unf_hold", 32'(a_rd), 32'h0F);
        clr();

        // pointer wrap
        for (int i = 0; i < 10; i++) wr(DW'(8'h10 + i));
        for (int i = 0; i < 10; i++) rd();
        for (int i = 0; i < 12; i++) wr(DW'(8'hA0 + i));
        for (int i = 0; i < 12; i++) begin
            rd();
            chk("wrap", 32'(a_rd), 32'(8'hA0 + i));
        end
        chk("wrap_count", 32'(a_count), 0);

        // simultaneous requests
        for (int i = 0; i < 5; i++) wr(DW'(8'h20 + i));
        cyc(1'b1, 8'h30, 1'b1, 1'b0, 1'b1);
        chk("sim5_count", 32'(a_count), 5);
        chk("sim5_rd",    32'(a_rd), 32'h20);
        for (int i = 0; i < 11; i++) wr(DW'(8'h40 + i));
        chk("sim_full", 32'(a_full), 1);
        cyc(1'b1, 8'h99, 1'b1, 1'b0, 1'b1);
        chk("simf_count", 32'(a_count), 15);
        chk("simf_ovf",   32'(a_ovf), 1);
        clr();
        chk("clr_ovf", 32'(a_ovf), 0);
        wr(8'h61);
        cyc(1'b1, 8'h62, 1'b0, 1'b1, 1'b1);
        chk("clr_vs_set", 32'(a_ovf), 1);
        clr();
        for (int i = 0; i < 16; i++) rd();
        chk("sim_drained", 32'(a_empty), 1);
        saved = m_rd;
        cyc(1'b1, 8'h55, 1'b1, 1'b0, 1'b1);
        chk("sime_count", 32'(a_count), 1);
        chk("sime_unf",   32'(a_unf), 1);
        chk("sime_rd",    32'(a_rd), 32'(saved));
        rd();
        chk("sime_pop", 32'(a_rd), 32'h55);

        // FWFT presentation and mid-operation reset
        wr(8'h3C);
        chk("fwft_empty", 32'(b_empty), 0);
        chk("fwft_data",  32'(b_rd), 32'h3C);
        for (int i = 0; i < 6; i++) wr(DW'(8'h70 + i));
        chk("pre_rst_count", 32'(b_count), 7);
        chk("pre_rst_unf",   32'(b_unf), 1);
        cyc(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        chk("rst_mid_count", 32'(b_count), 0);
        chk("rst_mid_empty", 32'(b_empty), 1);
        chk("rst_mid_unf",   32'(b_unf), 0);
        chk("rst_mid_ovf",   32'(b_ovf), 0);
        chk("rst_mid_rd",    32'(a_rd), 0);
        wr(8'h81);
        rd();
        chk("post_rst_rd", 32'(a_rd), 32'h81);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
